// File: rtl/shift_subtract_divider.sv
// Sequential unsigned restoring divider producing one quotient bit per clock.
// Shares the start/busy/done handshake of the shift-add multiplier.
module shift_subtract_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH:0]   r, r_next;
  logic [WIDTH-1:0] q, q_next;
  logic [WIDTH-1:0] d, d_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] quotient_next, remainder_next;
  logic             dbz_next;
  logic [WIDTH:0]   shifted, diff;

  // A set MSB on the trial difference means the subtraction underflowed.
  assign shifted = {r[WIDTH-1:0], q[WIDTH-1]};
  assign diff    = shifted - {1'b0, d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    r_next         = r;
    q_next         = q;
    d_next         = d;
    count_next     = count;
    quotient_next  = quotient;
    remainder_next = remainder;
    dbz_next       = div_by_zero;

    case (state)
      IDLE: begin
        if (start) begin
          d_next     = divisor;
          q_next     = dividend;
          r_next     = '0;
          count_next = '0;
          dbz_next   = 1'b0;
          if (divisor == '0) begin
            state_next     = DONE;
            quotient_next  = '1;
            remainder_next = dividend;
            dbz_next       = 1'b1;
          end else begin
            state_next = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (!diff[WIDTH]) begin
          r_next = diff;
          q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
          r_next = shifted;
          q_next = {q[WIDTH-2:0], 1'b0};
        end
        count_next = count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          state_next     = DONE;
          quotient_next  = q_next;
          remainder_next = r_next[WIDTH-1:0];
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // busy and done are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r           <= r_next;
      q           <= q_next;
      d           <= d_next;
      count       <= count_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
      div_by_zero <= dbz_next;
      busy        <= (state_next == DIVIDE);
      done        <= (state_next == DONE);
    end
  end

endmodule
